decade_chain_ctrl: RTL and testbench

- Stopwatch-style sequencer for a chain of NDIG decade (0-9) digit counters.
- Divides clk into count ticks with a prescaler and decodes start/stop/clear commands through a 4-state FSM.
- Generates per-digit enables with ripple-carry rules and flags overflow.
- Sits between the board button/pulse logic and the 7-segment display drivers.

---
 rtl/decade_chain_pkg.sv | 29 ++
 rtl/decade_digit.sv | 26 ++
 rtl/decade_chain_ctrl.sv | 133 +++++++++++++
 tb/tb_decade_chain_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decade_chain_pkg.sv
// Shared types and helpers for the decade digit chain sequencer.
// Holds the FSM state enum, BCD constants and the all-nines decode.
package decade_chain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // True when the lowest n digits of v are all 9 (n=0 gives 1).
  function automatic logic all_nines(
    input logic [31:0] v,
    input int          n
  );
    logic r;
    r = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < n && v[i*4 +: 4] != BCD_MAX)
        r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/decade_digit.sv
// One BCD decade register: clr zeroes, en steps 0..9 and wraps.
// Ports: clk, rst (async active-low), clr, en, q[3:0], carry_out (q==9).
import decade_chain_pkg::*;

module decade_digit (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  // Any value at or above 9 reloads 0, so forced non-BCD values heal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= (q >= BCD_MAX) ? '0 : q + 1'b1;
  end

  assign carry_out = (q == BCD_MAX);

endmodule

// File: rtl/decade_chain_ctrl.sv
// Stopwatch sequencer: prescaler, start/stop/clear FSM, NDIG-digit chain.
// Ports: clk, rst (async active-low), start, stop, clear -> digits,
// running, tick, ovf. Macro DECADE_CHAIN_LAP_EN adds lap/frozen.
import decade_chain_pkg::*;

module decade_chain_ctrl #(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 10,
  parameter int ROLLOVER = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
`ifdef DECADE_CHAIN_LAP_EN
  input  logic              lap,
  output logic              frozen,
`endif
  output logic [4*NDIG-1:0] digits,
  output logic              running,
  output logic              tick,
  output logic              ovf
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST =
    PW'(TICK_DIV - 1);

  state_t            state, state_nx;
  logic [PW-1:0]     presc, presc_nx;
  logic [4*NDIG-1:0] live;
  logic [NDIG-1:0]   carry;
  logic [NDIG-1:0]   en;
  logic              wrap_all;
  logic              adv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      presc <= '0;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    if (clear) begin
      state_nx = IDLE;
      presc_nx = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nx = RUN;
            presc_nx = '0;
          end
        end
        RUN: begin
          // Saturation wins over a same-cycle stop.
          if (ovf && ROLLOVER == 0)
            state_nx = DONE;
          else if (stop)
            state_nx = PAUSE;
          if (!stop)
            presc_nx = tick ? '0 : presc + 1'b1;
        end
        PAUSE: begin
          if (start)
            state_nx = RUN;
        end
        DONE: ;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state == RUN);
    tick    = running && (presc == P_LAST);
    ovf     = tick && wrap_all;
  end

  assign wrap_all = &carry;

  // In saturate mode the all-9s tick must not wrap the chain.
  assign adv = tick && !clear &&
               !(ROLLOVER == 0 && wrap_all);

  always_comb begin
    en = '0;
    for (int k = 0; k < NDIG; k++)
      en[k] = adv && all_nines(32'(live), k);
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    decade_digit u_dig (
      .clk       (clk),
      .rst       (rst),
      .clr       (clear),
      .en        (en[k]),
      .q         (live[k*4 +: 4]),
      .carry_out (carry[k])
    );
  end

`ifdef DECADE_CHAIN_LAP_EN
  logic [4*NDIG-1:0] snap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap   <= '0;
      frozen <= 1'b0;
    end else if (clear) begin
      frozen <= 1'b0;
    end else if (lap &&
                 (state == RUN || state == PAUSE)) begin
      if (!frozen)
        snap <= live;
      frozen <= !frozen;
    end
  end

  assign digits = frozen ? snap : live;
`else
  assign digits = live;
`endif

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Bench for decade_chain_ctrl: NDIG=2, TICK_DIV=4, both ROLLOVER modes.
// Integer-count reference model plus directed literal checks.
module tb_decade_chain_ctrl;

  localparam int NDIG = 2;
  localparam int DIV  = 4;
  localparam int MAX  = 99;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic clear = 1'b0;
  logic lap   = 1'b0;

  logic [7:0] dg [2];
  logic       run [2];
  logic       tk [2];
  logic       ov [2];
  logic       fz [2];

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  // Model: 0 idle, 1 run, 2 pause, 3 done.
  int m_st [2];
  int m_p [2];
  int m_cnt [2];
  int m_fz [2];
  int m_snap [2];
  int ro [2] = '{0, 1};

  always #5 clk = ~clk;

  decade_chain_ctrl #(
    .NDIG(NDIG), .TICK_DIV(DIV), .ROLLOVER(0)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .clear(clear),
`ifdef DECADE_CHAIN_LAP_EN
    .lap(lap), .frozen(fz[0]),
`endif
    .digits(dg[0]), .running(run[0]),
    .tick(tk[0]), .ovf(ov[0])
  );

  decade_chain_ctrl #(
    .NDIG(NDIG), .TICK_DIV(DIV), .ROLLOVER(1)
  ) u_wrap (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .clear(clear),
`ifdef DECADE_CHAIN_LAP_EN
    .lap(lap), .frozen(fz[1]),
`endif
    .digits(dg[1]), .running(run[1]),
    .tick(tk[1]), .ovf(ov[1])
  );

`ifndef DECADE_CHAIN_LAP_EN
  assign fz[0] = 1'b0;
  assign fz[1] = 1'b0;
`endif

  function automatic logic [7:0] bcd(input int v);
    return 8'((((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic mstep(input int i);
    bit tick_m, full;
    tick_m = (m_st[i] == 1) && (m_p[i] == DIV - 1);
    full   = (m_cnt[i] == MAX);
    if (clear) begin
      m_st[i]  = 0;
      m_p[i]   = 0;
      m_cnt[i] = 0;
      m_fz[i]  = 0;
    end else begin
`ifdef DECADE_CHAIN_LAP_EN
      if (lap && (m_st[i] == 1 || m_st[i] == 2)) begin
        if (m_fz[i] == 0)
          m_snap[i] = m_cnt[i];
        m_fz[i] = (m_fz[i] == 0) ? 1 : 0;
      end
`endif
      case (m_st[i])
        0: if (start) begin
          m_st[i] = 1;
          m_p[i]  = 0;
        end
        1: begin
          if (tick_m) begin
            if (!full)
              m_cnt[i] = m_cnt[i] + 1;
            else if (ro[i] != 0)
              m_cnt[i] = 0;
          end
          if (tick_m && full && ro[i] == 0)
            m_st[i] = 3;
          else if (stop)
            m_st[i] = 2;
          if (!stop)
            m_p[i] = (m_p[i] + 1) % DIV;
        end
        2: if (start) m_st[i] = 1;
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i]   = 0;
        m_p[i]    = 0;
        m_cnt[i]  = 0;
        m_fz[i]   = 0;
        m_snap[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++)
        mstep(i);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        bit et;
        et = (m_st[i] == 1) && (m_p[i] == DIV - 1);
        check($sformatf("digits%0d", i), dg[i],
              m_fz[i] != 0 ? bcd(m_snap[i]) : bcd(m_cnt[i]));
        check($sformatf("running%0d", i), run[i],
              m_st[i] == 1);
        check($sformatf("tick%0d", i), tk[i], et);
        check($sformatf("ovf%0d", i), ov[i],
              et && m_cnt[i] == MAX);
        check($sformatf("frozen%0d", i), fz[i],
              m_fz[i] != 0);
      end
    end
  end

  task automatic pulse(input logic s, input logic p,
                       input logic c);
    start = s;
    stop  = p;
    clear = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1 cmp_on = 1'b1;
    @(negedge clk);
    check("rst_digits", dg[1], 8'h00);
    check("rst_running", run[1], 1'b0);
    #1 rst = 1'b1;

    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("start_running", run[1], 1'b1);
    check("start_no_tick", tk[1], 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("first_tick", tk[1], 1'b1);
    check("first_tick_dig", dg[1], 8'h00);
    @(negedge clk);
    check("dig_01", dg[1], 8'h01);
    repeat (36) @(posedge clk);
    @(negedge clk);
    check("dig_10", dg[1], 8'h10);
    check("dig_10_sat", dg[0], 8'h10);

    repeat (359) @(posedge clk);
    @(negedge clk);
    check("ovf_wrap", ov[1], 1'b1);
    check("ovf_sat", ov[0], 1'b1);
    check("at_99", dg[0], 8'h99);
    @(negedge clk);
    check("wrap_dig", dg[1], 8'h00);
    check("wrap_run", run[1], 1'b1);
    check("sat_dig", dg[0], 8'h99);
    check("sat_run", run[0], 1'b0);
    check("sat_ovf_once", ov[0], 1'b0);

    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("done_start_ign", run[0], 1'b0);
    check("done_hold", dg[0], 8'h99);

    pulse(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("clr_start_run", run[1], 1'b0);
    check("clr_dig_wrap", dg[1], 8'h00);
    check("clr_dig_sat", dg[0], 8'h00);

    pulse(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("idle_start_stop", run[1], 1'b1);

    repeat (2) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    check("paused", run[1], 1'b0);
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("resume_no_tick", tk[1], 1'b0);
    @(negedge clk);
    check("resume_tick", tk[1], 1'b1);
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    check("stop_tick_inc", dg[1], 8'h01);
    check("stop_tick_pause", run[1], 1'b0);

    pulse(1'b1, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_dig", dg[1], 8'h00);
    check("async_run", run[1], 1'b0);
    check("async_tick", tk[1], 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;

    for (int n = 0; n < 25000; n++) begin
      @(posedge clk);
      #1;
      if (n < 20000)
        clear = ($urandom_range(0, 1499) == 0);
      else
        clear = ($urandom_range(0, 99) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 7) == 0);
      lap   = ($urandom_range(0, 59) == 0);
    end
    @(posedge clk);
    #1;
    {start, stop, clear, lap} = '0;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
